// File: rtl/fifo_packetizer.sv
// Groups the CDC FIFO's read-side word stream into packets closed by a
// {magic, seq, count} trailer word; partial packets close on idle timeout or flush.
module fifo_packetizer #(
    parameter int         INT_DATA_WIDTH     = 32,
    parameter int         INT_MAX_PAYLOAD    = 64,
    parameter int         INT_TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] INT_MAGIC          = 8'hA5
) (
    input  logic                      rd_clk,
    input  logic                      rd_rst,
    input  logic [INT_DATA_WIDTH-1:0] i_data,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic [INT_DATA_WIDTH-1:0] o_data,
    output logic                      o_data_valid,
    output logic                      o_last,
    input  logic                      i_dready,
    input  logic                      i_flush,
    output logic [15:0]               o_pkt_cnt,
    output logic                      o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_TRAILER
    } state_t;

    localparam logic [15:0] MAX_CNT    = 16'(INT_MAX_PAYLOAD);
    localparam bit          TIMEOUT_EN = (INT_TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TIMER_LAST = TIMEOUT_EN ? 16'(INT_TIMEOUT_CYCLES - 1) : 16'd0;

    state_t                    state_q, state_d;
    logic [INT_DATA_WIDTH-1:0] data_q, data_d;
    logic                      vld_q, vld_d;
    logic                      last_q, last_d;
    logic [15:0]               count_q, count_d;
    logic [15:0]               timer_q, timer_d;
    logic [15:0]               pkt_cnt_q, pkt_cnt_d;
    logic [7:0]                seq_q, seq_d;

    logic                      slot_free;
    logic                      accept;
    logic [15:0]               count_inc;

    // Trailer occupies the low 32 bits; any wider data bits are zero.
    function automatic logic [INT_DATA_WIDTH-1:0] make_trailer(input logic [7:0]  seq,
                                                               input logic [15:0] cnt);
        logic [INT_DATA_WIDTH-1:0] w;
        w       = '0;
        w[31:0] = {INT_MAGIC, seq, cnt};
        return w;
    endfunction

    assign slot_free = !vld_q || i_dready;
    assign o_ready   = !rd_rst && (state_q != S_TRAILER) && slot_free;
    assign accept    = i_valid && o_ready;
    assign count_inc = count_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        vld_d     = vld_q && !i_dready;
        last_d    = last_q;
        count_d   = count_q;
        timer_d   = timer_q;
        pkt_cnt_d = pkt_cnt_q;
        seq_d     = seq_q;

        case (state_q)
            S_IDLE, S_PAYLOAD: begin
                if (accept) begin
                    data_d  = i_data;
                    vld_d   = 1'b1;
                    last_d  = 1'b0;
                    count_d = count_inc;
                    timer_d = 16'd0;
                    // A flush alongside an accept still includes that word.
                    if ((count_inc == MAX_CNT) || i_flush) begin
                        state_d = S_TRAILER;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end else if (state_q == S_PAYLOAD) begin
                    timer_d = timer_q + 16'd1;
                    if (i_flush || (TIMEOUT_EN && (timer_q == TIMER_LAST))) begin
                        state_d = S_TRAILER;
                    end
                end
            end
            S_TRAILER: begin
                if (slot_free) begin
                    data_d    = make_trailer(seq_q, count_q);
                    vld_d     = 1'b1;
                    last_d    = 1'b1;
                    seq_d     = seq_q + 8'd1;
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                    count_d   = 16'd0;
                    timer_d   = 16'd0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            vld_q     <= 1'b0;
            last_q    <= 1'b0;
            count_q   <= 16'd0;
            timer_q   <= 16'd0;
            pkt_cnt_q <= 16'd0;
            seq_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            last_q    <= last_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            pkt_cnt_q <= pkt_cnt_d;
            seq_q     <= seq_d;
        end
    end

    assign o_data       = data_q;
    assign o_data_valid = vld_q;
    assign o_last       = last_q;
    assign o_pkt_cnt    = pkt_cnt_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_packetizer.sv
// Bench for fifo_packetizer: directed framing/timing cases plus a randomized
// run scored against a packet-level reference model.
module tb_fifo_packetizer;

    localparam int MAX = 4;
    localparam int TO  = 16;

    logic        clk = 1'b0;
    logic        rd_rst;
    logic [31:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] o_data;
    logic        o_data_valid;
    logic        o_last;
    logic        i_dready;
    logic        i_flush;
    logic [15:0] o_pkt_cnt;
    logic        o_busy;

    fifo_packetizer #(
        .INT_DATA_WIDTH    (32),
        .INT_MAX_PAYLOAD   (MAX),
        .INT_TIMEOUT_CYCLES(TO),
        .INT_MAGIC         (8'hA5)
    ) dut (
        .rd_clk      (clk),
        .rd_rst      (rd_rst),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_data_valid(o_data_valid),
        .o_last      (o_last),
        .i_dready    (i_dready),
        .i_flush     (i_flush),
        .o_pkt_cnt   (o_pkt_cnt),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: expected output stream as {last, word}
    logic [32:0] expq[$];
    int          m_cnt  = 0;
    int          m_idle = 0;
    logic [7:0]  m_seq  = 8'd0;
    int          m_pkts = 0;

    logic        rdy_s;
    logic        acc_s;
    logic        hold_pend = 1'b0;
    logic [31:0] held_data;
    logic        held_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic close_pkt();
        expq.push_back({1'b1, 8'hA5, m_seq, 16'(m_cnt)});
        m_seq  = m_seq + 8'd1;
        m_pkts++;
        m_cnt  = 0;
        m_idle = 0;
    endtask

    task automatic model_step(input logic acc, input logic fl, input logic [31:0] d);
        if (acc) begin
            expq.push_back({1'b0, d});
            m_cnt++;
            m_idle = 0;
            if (m_cnt == MAX || fl) close_pkt();
        end else if (m_cnt > 0) begin
            if (fl) close_pkt();
            else begin
                m_idle++;
                if (m_idle == TO) close_pkt();
            end
        end
    endtask

    // One clock: drive at negedge, sample handshakes before the edge, return just after it.
    task automatic tick(input logic v, input logic [31:0] d, input logic dr, input logic fl);
        logic [32:0] e;
        logic        ohs;
        @(negedge clk);
        i_valid  = v;
        i_data   = d;
        i_dready = dr;
        i_flush  = fl;
        #1;
        if (hold_pend) begin
            check("bp_hold_data", 64'(o_data), 64'(held_data));
            check("bp_hold_last", 64'(o_last), 64'(held_last));
        end
        hold_pend = 1'b0;
        rdy_s = o_ready;
        acc_s = i_valid && o_ready;
        ohs   = o_data_valid && i_dready;
        if (rd_rst) begin
            check("rst_ready", 64'(o_ready), 64'(0));
            expq.delete();
            m_cnt  = 0;
            m_idle = 0;
            m_seq  = 8'd0;
            m_pkts = 0;
        end else begin
            if (ohs) begin
                if (expq.size() == 0) begin
                    check("sb_unexpected_word", 64'(o_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    check("sb_data", 64'(o_data), 64'(e[31:0]));
                    check("sb_last", 64'(o_last), 64'(e[32]));
                end
            end
            if (o_data_valid && !i_dready) begin
                check("bp_ready_low", 64'(o_ready), 64'(0));
                hold_pend = 1'b1;
                held_data = o_data;
                held_last = o_last;
            end
            model_step(acc_s, fl, d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic send(input logic [31:0] w);
        int tries;
        tries = 0;
        acc_s = 1'b0;
        while (!acc_s && tries < 10) begin
            tick(1'b1, w, 1'b1, 1'b0);
            tries++;
        end
        if (!acc_s) check("send_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        rd_rst   = 1'b1;
        i_valid  = 1'b0;
        i_data   = 32'd0;
        i_dready = 1'b1;
        i_flush  = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 1'b1, 1'b0);
        rd_rst = 1'b0;
        check("rst_data", 64'(o_data), 64'(0));
        check("rst_valid", 64'(o_data_valid), 64'(0));
        check("rst_last", 64'(o_last), 64'(0));
        check("rst_pkt_cnt", 64'(o_pkt_cnt), 64'(0));
        check("rst_busy", 64'(o_busy), 64'(0));

        // Full packet 1,2,3,4
        for (int w = 1; w <= 4; w++) begin
            tick(1'b1, 32'(w), 1'b1, 1'b0);
            check("full_ready_hi", 64'(rdy_s), 64'(1));
        end
        check("full_word4", 64'(o_data), 64'(4));
        check("full_word4_last", 64'(o_last), 64'(0));
        tick(1'b0, 32'd0, 1'b1, 1'b0);
        check("full_ready_lo", 64'(rdy_s), 64'(0));
        check("full_trailer", 64'(o_data), 64'h0000_0000_A500_0004);
        check("full_trailer_last", 64'(o_last), 64'(1));
        check("full_pkt_cnt", 64'(o_pkt_cnt), 64'(1));
        tick(1'b0, 32'd0, 1'b1, 1'b0);
        check("full_ready_back", 64'(rdy_s), 64'(1));

        // Idle timeout on a two-word packet
        tick(1'b1, 32'h11, 1'b1, 1'b0);
        tick(1'b1, 32'h22, 1'b1, 1'b0);
        for (int i = 1; i <= TO + 1; i++) begin
            tick(1'b0, 32'd0, 1'b1, 1'b0);
            if (i == TO) begin
                check("to_early_last", 64'(o_last), 64'(0));
                check("to_early_busy", 64'(o_busy), 64'(1));
            end
        end
        check("to_trailer", 64'(o_data), 64'h0000_0000_A501_0002);
        check("to_trailer_last", 64'(o_last), 64'(1));
        check("to_busy_fall", 64'(o_busy), 64'(0));

        // Backpressure for 10 cycles mid-packet
        tick(1'b1, 32'h30, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 32'h31, 1'b0, 1'b0);
            check("bp_ready", 64'(rdy_s), 64'(0));
            check("bp_data", 64'(o_data), 64'h30);
        end
        tick(1'b1, 32'h31, 1'b1, 1'b0);
        check("bp_resume", 64'(acc_s), 64'(1));
        tick(1'b1, 32'h32, 1'b1, 1'b0);
        tick(1'b1, 32'h33, 1'b1, 1'b0);
        idle(3);

        // Flush: ignored when idle, closes a one-word packet when paired with an accept
        tick(1'b0, 32'd0, 1'b1, 1'b1);
        idle(3);
        check("flush_idle_valid", 64'(o_data_valid), 64'(0));
        check("flush_idle_busy", 64'(o_busy), 64'(0));
        check("flush_idle_cnt", 64'(o_pkt_cnt), 64'(3));
        tick(1'b1, 32'd7, 1'b1, 1'b1);
        check("flush_word", 64'(o_data), 64'(7));
        tick(1'b0, 32'd0, 1'b1, 1'b0);
        check("flush_trailer", 64'(o_data), 64'h0000_0000_A503_0001);
        check("flush_trailer_last", 64'(o_last), 64'(1));
        check("flush_pkt_cnt", 64'(o_pkt_cnt), 64'(4));

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 19) == 0));
        end
        idle(TO + 24);
        check("rand_drained", 64'(expq.size()), 64'(0));
        check("rand_busy", 64'(o_busy), 64'(0));
        check("rand_pkt_cnt", 64'(o_pkt_cnt), 64'(16'(m_pkts)));

        // Reset mid-packet with a held word
        tick(1'b1, 32'h41, 1'b1, 1'b0);
        tick(1'b1, 32'h42, 1'b1, 1'b0);
        rd_rst = 1'b1;
        tick(1'b0, 32'd0, 1'b0, 1'b0);
        rd_rst = 1'b0;
        check("mrst_data", 64'(o_data), 64'(0));
        check("mrst_valid", 64'(o_data_valid), 64'(0));
        check("mrst_last", 64'(o_last), 64'(0));
        check("mrst_pkt_cnt", 64'(o_pkt_cnt), 64'(0));
        check("mrst_busy", 64'(o_busy), 64'(0));
        tick(1'b1, 32'h51, 1'b1, 1'b0);
        tick(1'b1, 32'h52, 1'b1, 1'b0);
        tick(1'b1, 32'h53, 1'b1, 1'b1);
        tick(1'b0, 32'd0, 1'b1, 1'b0);
        check("mrst_trailer", 64'(o_data), 64'h0000_0000_A500_0003);

        // Sequence byte wrap: 256 more full packets
        for (int p = 0; p < 256; p++) begin
            for (int w = 0; w < MAX; w++) send(32'((p << 8) | w));
        end
        idle(3);
        check("wrap_pkt_cnt", 64'(o_pkt_cnt), 64'(257));
        check("wrap_trailer", 64'(o_data), 64'h0000_0000_A500_0004);
        check("wrap_drained", 64'(expq.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
